mem2io_ctrl: RTL and testbench

- Parametrised memory/IO controller between the SLC-3 datapath (MAR/MDR) and external SRAM.
- Decodes memory-mapped IO: switch read, hex-display write, and a new LED register.
- Adds a request/acknowledge handshake and configurable SRAM wait states; the CPU FSM no longer hard-codes memory timing.
- Adds a debug mode that routes the last accessed address to the hex display.

---
 rtl/mem2io_ctrl.sv | 133 +++++++++++++
 tb/tb_mem2io_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem2io_ctrl.sv
// Memory/IO controller between the SLC-3 MAR/MDR datapath and external SRAM.
// Decodes switch/hex/LED IO, inserts SRAM wait states and answers with a one-cycle Ack.
module mem2io_ctrl #(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int WAIT_STATES = 2,
    parameter int NUM_HEX     = 4,
    parameter int SW_W        = 10,
    parameter int LED_W       = 10,
    parameter logic [AW-1:0] HEX_ADDR = '1,
    parameter logic [AW-1:0] LED_ADDR = {{(AW-1){1'b1}}, 1'b0}
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req,
    input  logic                 Req_WE,
    input  logic [AW-1:0]        ADDR,
    input  logic [DW-1:0]        Data_from_CPU,
    output logic [DW-1:0]        Data_to_CPU,
    output logic                 Ack,
    input  logic                 Debug,
    input  logic [SW_W-1:0]      Switches,
    output logic [4*NUM_HEX-1:0] HEX,
    output logic [LED_W-1:0]     LED,
    output logic [AW-1:0]        SRAM_ADDR,
    input  logic [DW-1:0]        Data_from_SRAM,
    output logic [DW-1:0]        Data_to_SRAM,
    output logic                 OE,
    output logic                 WE,
    output logic [1:0]           state_dbg
);

    // Handshake: Req/Req_WE/ADDR/Data_from_CPU are sampled only in IDLE and must be
    // held until Ack; Ack is a single-cycle pulse, and Req seen in the IDLE cycle after
    // Ack starts the next access immediately.
    typedef enum logic [1:0] {S_IDLE, S_IO, S_SRAM, S_ACK} state_t;

    state_t                 state;
    logic [AW-1:0]          addr_q;
    logic [AW-1:0]          last_addr;
    logic                   we_q;
    logic [DW-1:0]          data_q;
    logic [3:0]             wait_cnt;
    logic [4*NUM_HEX-1:0]   hex_q;
    logic [DW-1:0]          sw_ext;
    logic [DW-1:0]          led_ext;
    logic                   is_io;

    always_comb begin
        sw_ext              = '0;
        sw_ext[SW_W-1:0]    = Switches;
        led_ext             = '0;
        led_ext[LED_W-1:0]  = LED;
    end

    assign is_io     = (ADDR == HEX_ADDR) || (ADDR == LED_ADDR);
    assign HEX       = Debug ? last_addr[4*NUM_HEX-1:0] : hex_q;
    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            Ack          <= 1'b0;
            OE           <= 1'b1;
            WE           <= 1'b1;
            SRAM_ADDR    <= '0;
            Data_to_SRAM <= '0;
            Data_to_CPU  <= '0;
            hex_q        <= '0;
            LED          <= '0;
            last_addr    <= '0;
            wait_cnt     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    Ack <= 1'b0;
                    if (Req) begin
                        addr_q    <= ADDR;
                        we_q      <= Req_WE;
                        data_q    <= Data_from_CPU;
                        last_addr <= ADDR;
                        if (is_io) begin
                            state <= S_IO;
                        end else begin
                            // SRAM strobes are registered here so they are active for
                            // exactly the WAIT_STATES+1 cycles spent in S_SRAM.
                            state     <= S_SRAM;
                            wait_cnt  <= 4'(WAIT_STATES);
                            SRAM_ADDR <= ADDR;
                            if (Req_WE) begin
                                WE           <= 1'b0;
                                Data_to_SRAM <= Data_from_CPU;
                            end else begin
                                OE <= 1'b0;
                            end
                        end
                    end
                end
                S_IO: begin
                    if (we_q) begin
                        if (addr_q == HEX_ADDR) hex_q <= data_q[4*NUM_HEX-1:0];
                        else                    LED   <= data_q[LED_W-1:0];
                    end else begin
                        Data_to_CPU <= (addr_q == HEX_ADDR) ? sw_ext : led_ext;
                    end
                    Ack   <= 1'b1;
                    state <= S_ACK;
                end
                S_SRAM: begin
                    if (wait_cnt == 4'd0) begin
                        if (!we_q) Data_to_CPU <= Data_from_SRAM;
                        OE           <= 1'b1;
                        WE           <= 1'b1;
                        Data_to_SRAM <= '0;
                        Ack          <= 1'b1;
                        state        <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    Ack   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem2io_ctrl.sv
// Bench for mem2io_ctrl: directed plan steps plus random accesses scored
// against a transaction-level model of memory, IO registers and timing.
module tb_mem2io_ctrl;

    localparam int WS = 2;
    localparam logic [15:0] HEX_A = 16'hFFFF;
    localparam logic [15:0] LED_A = 16'hFFFE;

    logic        Clk, Reset, Req, Req_WE, Debug, Ack, OE, WE;
    logic [15:0] ADDR, Data_from_CPU, Data_to_CPU, HEX, SRAM_ADDR, Data_from_SRAM, Data_to_SRAM;
    logic [9:0]  Switches, LED;
    logic [1:0]  state_dbg;

    mem2io_ctrl #(.DW(16), .AW(16), .WAIT_STATES(WS), .NUM_HEX(4), .SW_W(10), .LED_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Req_WE(Req_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Ack(Ack),
        .Debug(Debug), .Switches(Switches), .HEX(HEX), .LED(LED),
        .SRAM_ADDR(SRAM_ADDR), .Data_from_SRAM(Data_from_SRAM),
        .Data_to_SRAM(Data_to_SRAM), .OE(OE), .WE(WE), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // external SRAM device
    logic [15:0] sram_dev [logic [15:0]];
    always @(posedge Clk) if (WE === 1'b0) sram_dev[SRAM_ADDR] = Data_to_SRAM;
    always @(negedge Clk)
        Data_from_SRAM = sram_dev.exists(SRAM_ADDR) ? sram_dev[SRAM_ADDR] : 16'hDEAD;

    // reference model state
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] hex_m, last_m, dcpu_m;
    logic [9:0]  led_m;
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // driver: one access, returns observed read data, latency and strobe counts
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat, output int oe_lo,
                          output int we_lo, output logic bus_ok);
        @(negedge Clk);
        Req = 1'b1; Req_WE = we; ADDR = a; Data_from_CPU = d;
        @(posedge Clk);
        lat = 0; oe_lo = 0; we_lo = 0; bus_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            lat++;
            if (OE === 1'b0) oe_lo++;
            if (WE === 1'b0) begin
                we_lo++;
                if (Data_to_SRAM !== d) bus_ok = 1'b0;
            end else if (Data_to_SRAM !== 16'h0) bus_ok = 1'b0;
            if ((OE === 1'b0 || WE === 1'b0) && SRAM_ADDR !== a) bus_ok = 1'b0;
            if (Ack === 1'b1) break;
        end
        rd = Data_to_CPU;
        Req = 1'b0; Req_WE = 1'b0; ADDR = 16'($urandom); Data_from_CPU = 16'($urandom);
    endtask

    // scoreboard step: run one access and compare with the model
    task automatic run_op(input string tag, input logic we, input logic [15:0] a,
                          input logic [15:0] d);
        logic [15:0] rd;
        int lat, oe_lo, we_lo;
        logic bus_ok, io;
        io = (a == HEX_A) || (a == LED_A);
        access(we, a, d, rd, lat, oe_lo, we_lo, bus_ok);
        if (we) begin
            if (!io)             ref_mem[a] = d;
            else if (a == HEX_A) hex_m = d;
            else                 led_m = d[9:0];
        end else begin
            if (!io)             dcpu_m = ref_mem[a];
            else if (a == HEX_A) dcpu_m = {6'b0, Switches};
            else                 dcpu_m = {6'b0, led_m};
        end
        last_m = a;
        chk({tag, ".lat"},   32'(lat),   io ? 32'd2 : 32'(WS + 2));
        chk({tag, ".oe_lo"}, 32'(oe_lo), (!io && !we) ? 32'(WS + 1) : 32'd0);
        chk({tag, ".we_lo"}, 32'(we_lo), (!io && we) ? 32'(WS + 1) : 32'd0);
        chk({tag, ".bus"},   32'(bus_ok), 32'd1);
        chk({tag, ".rdata"}, 32'(rd),    32'(dcpu_m));
        chk({tag, ".hex"},   32'(HEX),   Debug ? 32'(last_m) : 32'(hex_m));
        chk({tag, ".led"},   32'(LED),   32'(led_m));
    endtask

    logic [15:0] pool [8];

    initial begin
        int n;
        logic [15:0] a;
        logic        we;
        Reset = 1'b1; Req = 1'b0; Req_WE = 1'b0; ADDR = '0; Data_from_CPU = '0;
        Debug = 1'b0; Switches = '0;
        hex_m = '0; led_m = '0; last_m = '0; dcpu_m = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rst.oe", 32'(OE), 32'd1);
        chk("rst.we", 32'(WE), 32'd1);
        chk("rst.ack", 32'(Ack), 32'd0);
        chk("rst.hex", 32'(HEX), 32'h0);
        chk("rst.led", 32'(LED), 32'h0);
        chk("rst.dcpu", 32'(Data_to_CPU), 32'h0);
        chk("rst.state", 32'(state_dbg), 32'd0);

        run_op("sram_wr", 1'b1, 16'h0040, 16'h1234);
        run_op("sram_rd", 1'b0, 16'h0040, 16'h0000);

        Switches = 10'h2A5;
        run_op("sw_rd", 1'b0, HEX_A, 16'h0000);
        run_op("hex_wr", 1'b1, HEX_A, 16'hBEEF);
        run_op("led_wr", 1'b1, LED_A, 16'h03FF);
        run_op("led_rd", 1'b0, LED_A, 16'h0000);
        @(negedge Clk) Debug = 1'b1;
        #1 chk("debug.hex", 32'(HEX), 32'hFFFE);
        @(negedge Clk) Debug = 1'b0;
        #1 chk("nodebug.hex", 32'(HEX), 32'hBEEF);

        // back-to-back IO reads with Req held through the Ack cycle
        @(negedge Clk);
        Req = 1'b1; Req_WE = 1'b0; ADDR = HEX_A;
        n = 0;
        for (int i = 0; i < 20 && Ack !== 1'b1; i++) @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n++;
            if (Ack === 1'b1) break;
        end
        Req = 1'b0;
        chk("b2b.gap", 32'(n), 32'd3);
        chk("b2b.rdata", 32'(Data_to_CPU), {22'b0, Switches});
        dcpu_m = {6'b0, Switches};
        last_m = HEX_A;

        // random accesses against the model
        pool = '{16'h0000, 16'h0001, 16'h0040, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFD, 16'hFFFC};
        for (int k = 0; k < 40; k++) begin
            Switches = 10'($urandom);
            Debug    = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       a = HEX_A;
                1:       a = LED_A;
                default: a = pool[$urandom_range(0, 7)];
            endcase
            we = 1'($urandom);
            if (!we && a != HEX_A && a != LED_A && !ref_mem.exists(a)) we = 1'b1;
            run_op("rnd", we, a, 16'($urandom));
        end
        Debug = 1'b0;

        // reset during the second SRAM read wait cycle
        @(negedge Clk);
        Req = 1'b1; Req_WE = 1'b0; ADDR = 16'h0040;
        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("mid_rst.oe", 32'(OE), 32'd1);
        chk("mid_rst.ack", 32'(Ack), 32'd0);
        chk("mid_rst.state", 32'(state_dbg), 32'd0);
        chk("mid_rst.dcpu", 32'(Data_to_CPU), 32'h0);
        @(negedge Clk) begin Reset = 1'b0; Req = 1'b0; end
        n = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Ack === 1'b1) n++;
        end
        chk("mid_rst.no_ack", 32'(n), 32'd0);
        chk("mid_rst.hex", 32'(HEX), 32'h0);
        chk("mid_rst.led", 32'(LED), 32'h0);
        hex_m = '0; led_m = '0; last_m = '0; dcpu_m = '0;
        run_op("post_rst_rd", 1'b0, 16'h0040, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
